// File: rtl/vec_load_ctrl.sv
// Vector immediate load controller: receives framed vectors from a host byte stream,
// stages them in RAM and bursts them into one of K shared-bus buffers, arbitrating with reads.
module vec_load_ctrl #(
  parameter int BITS = 8,
  parameter int N    = 64,
  parameter int K    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BITS-1:0]      rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [BITS-1:0]      buf_in,
  output logic [K-1:0]         buf_set,
  output logic [K-1:0]         buf_en,
  input  logic [K-1:0]         buf_done,
  input  logic                 rd_req,
  input  logic [$clog2(K)-1:0] rd_sel,
  output logic                 rd_gnt,
  output logic [K-1:0]         loaded,
  output logic                 busy,
  output logic                 err
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(K);
  localparam logic [BITS:0] K_L = (BITS+1)'(K);
  localparam logic [BITS:0] N_L = (BITS+1)'(N);

  typedef enum logic [2:0] {
    IDLE, GET_LEN, FILL, DISCARD, WAIT_BUS, SET, BURST, WAIT_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] tgt_q, tgt_d;
  logic [BITS-1:0] len_q, len_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [K-1:0]    loaded_q, loaded_d;
  logic            err_q, err_d;

  logic [BITS-1:0] mem [N];
  logic [BITS-1:0] rd_data_q;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;

  logic [TW-1:0]   tgt_idx;
  logic            accept;
  logic            last_cnt;
  logic            rd_hits_tgt;
  logic            fsm_owns_tgt;

  assign tgt_idx      = tgt_q[TW-1:0];
  assign rx_ready     = (state_q inside {IDLE, GET_LEN, FILL, DISCARD});
  assign accept       = rx_valid && rx_ready;
  assign last_cnt     = (cnt_q == len_q - 1'b1);
  assign rd_hits_tgt  = (BITS'(rd_sel) == tgt_q);
  assign fsm_owns_tgt = (state_q inside {SET, BURST, WAIT_DONE}) && rd_hits_tgt;

  // Reads never wait on the loader unless they target the buffer being written.
  assign rd_gnt  = rd_req && (int'(rd_sel) < K) && loaded_q[rd_sel] && !fsm_owns_tgt;
  assign buf_en  = rd_gnt ? (K'(1) << rd_sel) : '0;
  assign loaded  = loaded_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    rd_addr  = cnt_q[AW-1:0] + AW'(1);
    buf_set  = '0;
    buf_in   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = rx_data;
          state_d = GET_LEN;
        end
      end
      GET_LEN: begin
        if (accept) begin
          len_d = rx_data;
          cnt_d = '0;
          if (({1'b0, tgt_q} >= K_L) || ({1'b0, rx_data} > N_L)) begin
            err_d   = 1'b1;
            state_d = (rx_data == '0) ? IDLE : DISCARD;
          end else begin
            state_d = (rx_data == '0) ? WAIT_BUS : FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = WAIT_BUS;
          end
        end
      end
      DISCARD: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      WAIT_BUS: begin
        // loaded[T] drops only on leaving, so an in-flight read of T keeps its grant.
        if (!(rd_gnt && rd_hits_tgt)) begin
          loaded_d[tgt_idx] = 1'b0;
          state_d           = SET;
        end
      end
      SET: begin
        buf_set = K'(1) << tgt_idx;
        buf_in  = len_q;
        rd_addr = '0;
        cnt_d   = '0;
        state_d = (len_q == '0) ? WAIT_DONE : BURST;
      end
      BURST: begin
        buf_in = rd_data_q;
        cnt_d  = cnt_q + 1'b1;
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (buf_done[tgt_idx]) begin
          loaded_d[tgt_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // Staging RAM; read address runs one element ahead so BURST is gapless.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt_q[AW-1:0]] <= rx_data;
    end
    rd_data_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_vec_load_ctrl.sv
// Scoreboard bench for vec_load_ctrl: stimulus queues expected loads/err/loaded events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vec_load_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] buf_in;
  logic [3:0] buf_set;
  logic [3:0] buf_en;
  logic [3:0] buf_done;
  logic       rd_req = 1'b0;
  logic [1:0] rd_sel = '0;
  logic       rd_gnt;
  logic [3:0] loaded;
  logic       busy;
  logic       err;

  vec_load_ctrl #(.BITS(8), .N(64), .K(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .buf_in(buf_in), .buf_set(buf_set), .buf_en(buf_en), .buf_done(buf_done),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_gnt(rd_gnt), .loaded(loaded),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      set;
    logic [1:0]      t;
    logic [7:0]      len;
    logic [7:0][7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] ld_q[$];
  int         err_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic push_load(input logic [7:0] t, input logic [7:0] l, input logic [7:0][7:0] dd);
    exp_t e;
    e.set  = 4'b0001 << t[1:0];
    e.t    = t[1:0];
    e.len  = l;
    e.data = dd;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [7:0] l, input logic [7:0][7:0] dd);
    send_byte(t);
    send_byte(l);
    for (int i = 0; i < int'(l); i++) send_byte(dd[i % 8]);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: scoreboard for load bursts, err pulses and loaded changes; also models buffers' done.
  initial begin
    exp_t       cur;
    int         cap_left;
    int         cap_idx;
    logic [3:0] loaded_prev;
    cur         = '0;
    cap_left    = 0;
    cap_idx     = 0;
    loaded_prev = '0;
    buf_done    = '0;
    forever begin
      @(negedge clk);
      if (loaded !== loaded_prev) begin
        if (ld_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL loaded_unexpected actual=%0h expected=%0h", loaded, loaded_prev);
        end else begin
          chk("loaded", 32'(loaded), 32'(ld_q.pop_front()));
        end
        loaded_prev = loaded;
      end
      if (rst) begin
        cap_left = 0;
      end else begin
        if (err) begin
          chk("err_expected", 32'(err_q.size() != 0), 32'd1);
          if (err_q.size() != 0) void'(err_q.pop_front());
        end
        if (cap_left > 0) begin
          chk("burst_data", {20'd0, buf_set, buf_in}, {24'd0, cur.data[cap_idx]});
          cap_idx++;
          cap_left--;
          if (cap_left == 0) buf_done[cur.t] = 1'b1;
        end else if (buf_set != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL set_unexpected actual=%0h expected=0", buf_set);
          end else begin
            cur = exp_q.pop_front();
            chk("set_strobe", 32'(buf_set), 32'(cur.set));
            chk("set_len", 32'(buf_in), 32'(cur.len));
            buf_done[cur.t] = 1'b0;
            cap_left = int'(cur.len);
            cap_idx  = 0;
            if (cur.len == 0) buf_done[cur.t] = 1'b1;
          end
        end else begin
          chk("bus_idle", 32'(buf_in), 32'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][7:0] d;
    int              n;
    int              phase;
    int              w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {rx_ready, busy, err, rd_gnt, buf_set, buf_en, loaded, buf_in},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0});
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {30'd0, rx_ready, busy}, 32'b10);

    // Frame {1,3,A,B,C}: uncontested latency 1+1+3+1
    d = '0; d[0] = 8'h0A; d[1] = 8'h0B; d[2] = 8'h0C;
    push_load(8'd1, 8'd3, d);
    ld_q.push_back(4'b0010);
    send_frame(8'd1, 8'd3, d);
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("load_latency", 32'(n), 32'd6);
    chk("loaded_after_1", 32'(loaded), 32'b0010);

    // Rejected frames: bad target, length over N, bad target with zero length
    d = '0; d[0] = 8'h11; d[1] = 8'h22;
    err_q.push_back(1);
    send_frame(8'd5, 8'd2, d);
    wait_idle();
    chk("discard_loaded", {28'd0, loaded}, 32'b0010);
    err_q.push_back(1);
    send_frame(8'd0, 8'd65, d);
    wait_idle();
    err_q.push_back(1);
    send_frame(8'd6, 8'd0, d);
    wait_idle();
    chk("discard_ready", {30'd0, rx_ready, busy}, 32'b10);

    // Frame {0,0}: SET only
    d = '0;
    push_load(8'd0, 8'd0, d);
    ld_q.push_back(4'b0011);
    send_frame(8'd0, 8'd0, d);
    wait_idle();
    chk("loaded_after_0", 32'(loaded), 32'b0011);

    // Preload buffer 2, then hold a read of it across a new load of 2
    d = '0; d[0] = 8'h55;
    push_load(8'd2, 8'd1, d);
    ld_q.push_back(4'b0111);
    send_frame(8'd2, 8'd1, d);
    wait_idle();
    rd_sel = 2'd2;
    rd_req = 1'b1;
    #1 chk("rd2_idle_gnt", {27'd0, rd_gnt, buf_en}, {27'd0, 1'b1, 4'b0100});
    d = '0; d[0] = 8'h07;
    push_load(8'd2, 8'd1, d);
    ld_q.push_back(4'b0011);
    ld_q.push_back(4'b0111);
    send_frame(8'd2, 8'd1, d);
    repeat (5) @(negedge clk);
    chk("waitbus_hold", {24'd0, busy, rx_ready, rd_gnt, buf_en, buf_set[0]},
        {24'd0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0});
    chk("waitbus_noset", 32'(buf_set), 32'd0);
    rd_req = 1'b0;
    @(negedge clk);
    chk("set_after_release", {20'd0, buf_set, buf_in}, {20'd0, 4'b0100, 8'd1});
    wait_idle();

    // Preload buffer 3, then read it while buffer 0 loads
    d = '0; d[0] = 8'h33;
    push_load(8'd3, 8'd1, d);
    ld_q.push_back(4'b1111);
    send_frame(8'd3, 8'd1, d);
    wait_idle();
    rd_sel = 2'd3;
    rd_req = 1'b1;
    d = '0; d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03; d[3] = 8'h04;
    push_load(8'd0, 8'd4, d);
    ld_q.push_back(4'b1110);
    ld_q.push_back(4'b1111);
    send_frame(8'd0, 8'd4, d);
    phase = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      chk("rd3_during_load", {27'd0, rd_gnt, buf_en}, {27'd0, 1'b1, 4'b1000});
      if (phase == 1) begin
        rd_sel = 2'd0;
        #1 chk("rd0_blocked", {27'd0, rd_gnt, buf_en}, 32'd0);
        rd_sel = 2'd3;
        phase = 2;
      end
      if (phase == 0 && buf_set == 4'b0001) phase = 1;
    end
    chk("burst_phase_seen", 32'(phase), 32'd2);
    rd_req = 1'b0;
    wait_idle();

    // Reset in the middle of a burst
    d = '0; d[0] = 8'h09; d[1] = 8'h08; d[2] = 8'h07; d[3] = 8'h06;
    push_load(8'd1, 8'd4, d);
    ld_q.push_back(4'b1101);
    ld_q.push_back(4'b0000);
    send_frame(8'd1, 8'd4, d);
    w = 0;
    while (buf_set != 4'b0010 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_test_set_seen", 32'(buf_set), 32'b0010);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid_burst", {rx_ready, busy, err, buf_set, buf_en, loaded, buf_in},
           {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0});
    @(negedge clk);
    #2 rst = 1'b0;

    // Next frame after reset
    d = '0; d[0] = 8'h11; d[1] = 8'h22;
    push_load(8'd1, 8'd2, d);
    ld_q.push_back(4'b0010);
    send_frame(8'd1, 8'd2, d);
    wait_idle();
    chk("loaded_after_rst", 32'(loaded), 32'b0010);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("ld_q_empty", 32'(ld_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_load_ctrl.md
VEC_LOAD_CTRL -- requirements
Module: vec_load_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, element and byte width.
REQ-002 SHALL have parameter N, default 64, max vector length and staging depth (N <= 2^BITS-1).
REQ-003 SHALL have parameter K, default 4, number of vector immediate buffers controlled.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  BITS  host byte stream data.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  byte accepted on a cycle where rx_valid && rx_ready.
REQ-009 SHALL have port buf_in  output  BITS  shared data input to all buffers.
REQ-010 SHALL have port buf_set  output  K  one-hot set strobe per buffer.
REQ-011 SHALL have port buf_en  output  K  one-hot (or zero) output enable per buffer.
REQ-012 SHALL have port buf_done  input  K  done flag from each buffer.
REQ-013 SHALL have port rd_req  input  1  execution unit requests a buffer on the shared bus.
REQ-014 SHALL have port rd_sel  input  $clog2(K)  buffer index requested.
REQ-015 SHALL have port rd_gnt  output  1  selected buffer is driving the bus.
REQ-016 SHALL have port loaded  output  K  buffer holds a completed vector.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 SHALL have port err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-019 SHALL accept frames: byte 0 = target index T, byte 1 = length L, then L element bytes.
REQ-020 SHALL use FSM states IDLE, GET_LEN, FILL, DISCARD, WAIT_BUS, SET, BURST, WAIT_DONE.
REQ-021 SHALL assert rx_ready only in IDLE, GET_LEN, FILL, DISCARD.
REQ-022 IDLE: on accepted byte latch T -> GET_LEN.
REQ-023 GET_LEN: on accepted byte latch L; if T >= K or L > N -> pulse err, DISCARD (L bytes) or IDLE if L = 0; else L = 0 -> WAIT_BUS, else FILL.
REQ-024 FILL: write each accepted byte to staging RAM at count 0..L-1; after the L-th byte -> WAIT_BUS.
REQ-025 DISCARD: consume and drop L bytes, no buffer outputs change, then IDLE.
REQ-026 WAIT_BUS: clear loaded[T]; remain while rd_gnt is high with rd_sel == T; else -> SET.
REQ-027 SET: for exactly one cycle buf_set = 1<<T, buf_in = L -> BURST (or WAIT_DONE if L = 0).
REQ-028 BURST: drive buf_in = staged element j on the j-th cycle after SET, j = 0..L-1, gapless, -> WAIT_DONE.
REQ-029 WAIT_DONE: when buf_done[T] is high -> set loaded[T], IDLE; buf_done sampled only from the cycle after BURST ends.
REQ-030 buf_set SHALL be zero outside SET; buf_in SHALL be 0 outside SET/BURST.
REQ-031 rd_gnt and buf_en = 1<<rd_sel SHALL assert combinationally when rd_req && loaded[rd_sel] && !(state in SET/BURST/WAIT_DONE && rd_sel == T); else buf_en = 0.
REQ-032 buf_en SHALL never have more than one bit set.
REQ-033 A read of buffer T started in WAIT_BUS defers the load until rd_req drops or rd_sel changes.
REQ-034 Reads of buffers other than T SHALL be granted during any state.
REQ-035 Total load latency after the last frame byte SHALL be 1 (WAIT_BUS) + 1 (SET) + L (BURST) + 1..2 (WAIT_DONE) cycles when uncontested.

Reset
REQ-036 rst high SHALL asynchronously force IDLE, counters 0, loaded = 0, err = 0, buf_set = 0, buf_in = 0, rx_ready = 1 after release.
REQ-037 Reset mid-frame or mid-burst SHALL abandon the frame; partial buffer contents are not marked loaded.

Verification
REQ-038 Frame {1,3,0xA,0xB,0xC}, no reads -> buf_set = 0010 for one cycle with buf_in = 3, then buf_in = 0xA,0xB,0xC on consecutive cycles, loaded = 0010.
REQ-039 Frame {5,2,...} with K = 4 -> err pulse, 2 bytes discarded, loaded and buf_set unchanged.
REQ-040 Frame {0,0} -> buf_set = 0001 with buf_in = 0, loaded[0] set once buf_done[0] rises, no BURST cycles.
REQ-041 loaded[2] = 1, rd_req with rd_sel = 2 held while frame {2,1,0x7} arrives -> FSM waits in WAIT_BUS with buf_en = 0100; SET fires the cycle after rd_req drops.
REQ-042 Load of buffer 0 in BURST while rd_sel = 3 with loaded[3] -> buf_en = 1000 and rd_gnt = 1 throughout; rd_sel = 0 -> rd_gnt = 0.
REQ-043 rst asserted during BURST of frame {1,4,...} -> outputs at reset values immediately, loaded[1] = 0, next frame accepted normally.
